// File: rtl/seg_scan_decoder.sv
// Reads a multiplexed 7-segment bus back into a hex frame: sync, debounce per digit,
// glyph decode, frame assembly and a valid/ready output with overrun detection.
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter bit SEG_ACT_LOW   = 1'b1,
  parameter bit AN_ACT_LOW    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_an,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  output logic                    bad_pattern
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, LOCKED} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [7:0]              seg_s, prev_seg;
  logic [NUM_DIGITS-1:0]   an_s, prev_an;
  logic [NUM_DIGITS-1:0]   mask;
  logic [4*NUM_DIGITS-1:0] slot_val, merged_val;
  logic [NUM_DIGITS-1:0]   slot_dp, merged_dp;
  logic [IW-1:0]           dig_idx;
  logic [3:0]              nib;
  logic                    legal, same, active, restart, accept_now, frame_done;

  // Input sync stage, normalised so that lit segments and active strobes read as 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s    <= '0;
      an_s     <= '0;
      prev_seg <= '0;
      prev_an  <= '0;
    end else begin
      seg_s    <= SEG_ACT_LOW ? ~seg_in : seg_in;
      an_s     <= AN_ACT_LOW ? ~dig_an : dig_an;
      prev_seg <= seg_s;
      prev_an  <= an_s;
    end
  end

  always_comb begin
    legal = 1'b1;
    nib   = 4'h0;
    case (seg_s[6:0])
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    dig_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_s[i]) dig_idx = IW'(i);
    end
  end

  // A sample that is blank or lacks exactly one strobe never starts a debounce.
  assign same       = ({seg_s, an_s} == {prev_seg, prev_an});
  assign active     = $onehot(an_s) && (seg_s[6:0] != 7'h00);
  assign restart    = active && ((state == IDLE) || !same);
  assign accept_now = (restart && (STABLE_CYCLES == 1)) ||
                      ((state == COUNT) && same && (cnt == CW'(STABLE_CYCLES - 1)));
  assign frame_done = accept_now && legal && (&(mask | an_s));

  always_comb begin
    merged_val = slot_val;
    merged_dp  = slot_dp;
    merged_val[4*int'(dig_idx) +: 4] = nib;
    merged_dp[dig_idx]               = seg_s[7];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (accept_now) begin
      state <= LOCKED;
      cnt   <= CW'(STABLE_CYCLES);
    end else if (restart) begin
      state <= COUNT;
      cnt   <= CW'(1);
    end else if ((state == COUNT) && same) begin
      cnt <= cnt + 1'b1;
    end else if (!active) begin
      state <= IDLE;
      cnt   <= '0;
    end
  end

  // Frame assembly and output handshake; a completing frame takes priority over the drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_val    <= '0;
      slot_dp     <= '0;
      mask        <= '0;
      value_out   <= '0;
      dp_out      <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      bad_pattern <= 1'b0;
    end else begin
      bad_pattern <= accept_now && !legal;
      if (accept_now && legal) begin
        slot_val <= merged_val;
        slot_dp  <= merged_dp;
        mask     <= frame_done ? '0 : (mask | an_s);
      end
      if (frame_done) begin
        if (!out_valid || out_ready) begin
          value_out <= merged_val;
          dp_out    <= merged_dp;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans glyphs onto an active-low bus and
// checks decoded frames, debounce, illegal glyphs, overrun and reset behaviour.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg_in = 8'hFF;
  logic [3:0]  dig_an = 4'hF;
  logic [15:0] value_out;
  logic [3:0]  dp_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        overrun;
  logic        bad_pattern;

  int assert_count = 0;
  int fail_count   = 0;
  int hs_count     = 0;
  int valid_cycles = 0;
  int bad_count    = 0;
  int hs_base, vc_base, bad_base;
  logic [15:0] hs_value = '0;
  logic [3:0]  hs_dp    = '0;

  seg_scan_decoder #(
    .NUM_DIGITS(4), .STABLE_CYCLES(4), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_an(dig_an),
    .value_out(value_out), .dp_out(dp_out), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .bad_pattern(bad_pattern)
  );

  always #5 clk = ~clk;

  // Observe handshakes, valid cycles and bad-pattern pulses on the quiet edge.
  always @(negedge clk) begin
    if (out_valid) valid_cycles++;
    if (out_valid && out_ready) begin
      hs_count++;
      hs_value = value_out;
      hs_dp    = dp_out;
    end
    if (bad_pattern) bad_count++;
  end

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'h3F;  4'h1: glyph = 8'h06;  4'h2: glyph = 8'h5B;  4'h3: glyph = 8'h4F;
      4'h4: glyph = 8'h66;  4'h5: glyph = 8'h6D;  4'h6: glyph = 8'h7D;  4'h7: glyph = 8'h07;
      4'h8: glyph = 8'h7F;  4'h9: glyph = 8'h6F;  4'hA: glyph = 8'h77;  4'hB: glyph = 8'h7C;
      4'hC: glyph = 8'h39;  4'hD: glyph = 8'h5E;  4'hE: glyph = 8'h79;  default: glyph = 8'h71;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // seg_ah is the active-high pattern {dp,g..a}; the bus itself is driven active-low.
  task automatic applyStimulus(input int digit, input logic [7:0] seg_ah, input int cycles);
    dig_an = ~(4'b0001 << digit);
    seg_in = ~seg_ah;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic applyIdle(input int cycles);
    dig_an = 4'hF;
    seg_in = 8'hFF;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic applyDigit(input int digit, input logic [3:0] n, input logic dp);
    applyStimulus(digit, {dp, glyph(n)[6:0]}, 6);
  endtask

  task automatic scanFrame(input logic [15:0] v, input logic [3:0] dp);
    for (int d = 0; d < 4; d++) applyDigit(d, v[4*d +: 4], dp[d]);
  endtask

  initial begin
    #23;
    checkOutput("reset value_out", value_out, 16'h0000);
    checkOutput("reset dp_out", dp_out, 4'h0);
    checkOutput("reset out_valid", out_valid, 1'b0);
    checkOutput("reset overrun", overrun, 1'b0);
    checkOutput("reset bad_pattern", bad_pattern, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyIdle(2);

    $display("[TB] basic frame 4321");
    vc_base = valid_cycles;
    hs_base = hs_count;
    scanFrame(16'h4321, 4'b0000);
    checkOutput("t1 handshakes", hs_count - hs_base, 1);
    checkOutput("t1 valid cycles", valid_cycles - vc_base, 1);
    checkOutput("t1 value", hs_value, 16'h4321);
    checkOutput("t1 dp", hs_dp, 4'b0000);
    checkOutput("t1 valid dropped", out_valid, 1'b0);
    applyIdle(2);

    $display("[TB] glitch on digit 0");
    hs_base = hs_count;
    applyStimulus(0, glyph(4'h0), 2);
    applyStimulus(0, glyph(4'h1), 6);
    applyDigit(1, 4'h5, 1'b0);
    applyDigit(2, 4'h6, 1'b1);
    applyDigit(3, 4'h7, 1'b0);
    checkOutput("t2 handshakes", hs_count - hs_base, 1);
    checkOutput("t2 value", hs_value, 16'h7651);
    checkOutput("t2 dp", hs_dp, 4'b0100);
    applyIdle(2);

    $display("[TB] illegal glyph on digit 2");
    hs_base  = hs_count;
    bad_base = bad_count;
    applyStimulus(2, 8'h49, 6);
    checkOutput("t3 bad pulses", bad_count - bad_base, 1);
    applyDigit(0, 4'h9, 1'b0);
    applyDigit(1, 4'h8, 1'b0);
    applyDigit(3, 4'hA, 1'b0);
    checkOutput("t3 no frame", hs_count - hs_base, 0);
    checkOutput("t3 no valid", out_valid, 1'b0);
    applyDigit(2, 4'hB, 1'b0);
    checkOutput("t3 late frame", hs_count - hs_base, 1);
    checkOutput("t3 value", hs_value, 16'hAB89);
    applyIdle(2);

    $display("[TB] overrun");
    out_ready = 1'b0;
    scanFrame(16'h1234, 4'b0000);
    checkOutput("t4 first valid", out_valid, 1'b1);
    checkOutput("t4 first value", value_out, 16'h1234);
    checkOutput("t4 no overrun yet", overrun, 1'b0);
    scanFrame(16'h5678, 4'b0000);
    checkOutput("t4 held value", value_out, 16'h1234);
    checkOutput("t4 overrun", overrun, 1'b1);
    checkOutput("t4 still valid", out_valid, 1'b1);
    hs_base = hs_count;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("t4 valid falls", out_valid, 1'b0);
    checkOutput("t4 overrun sticky", overrun, 1'b1);
    checkOutput("t4 drained value", hs_value, 16'h1234);
    checkOutput("t4 drained once", hs_count - hs_base, 1);
    applyIdle(2);

    $display("[TB] reset then simultaneous complete and accept");
    #2 rst = 1'b1;
    #1;
    checkOutput("t5 overrun cleared", overrun, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyIdle(2);
    out_ready = 1'b0;
    scanFrame(16'h9876, 4'b0000);
    checkOutput("t5 pending valid", out_valid, 1'b1);
    applyDigit(0, 4'hD, 1'b0);
    applyDigit(1, 4'hC, 1'b0);
    applyDigit(2, 4'hB, 1'b0);
    applyStimulus(3, glyph(4'hA), 4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("t5 value", value_out, 16'hABCD);
    checkOutput("t5 valid held", out_valid, 1'b1);
    checkOutput("t5 overrun", overrun, 1'b0);
    @(posedge clk); #1;
    checkOutput("t5 valid falls", out_valid, 1'b0);
    applyIdle(2);

    $display("[TB] reset mid-scan");
    applyDigit(0, 4'h3, 1'b1);
    applyDigit(1, 4'h4, 1'b0);
    applyStimulus(2, glyph(4'h5), 3);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6 value cleared", value_out, 16'h0000);
    checkOutput("t6 valid cleared", out_valid, 1'b0);
    #3;
    @(posedge clk); #1;
    rst = 1'b0;
    hs_base = hs_count;
    vc_base = valid_cycles;
    applyIdle(2);
    applyDigit(2, 4'h5, 1'b0);
    applyDigit(3, 4'h6, 1'b0);
    applyIdle(4);
    checkOutput("t6 no frame", hs_count - hs_base, 0);
    checkOutput("t6 no valid", valid_cycles - vc_base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
